// File: rtl/sp_ram_param.sv
// sp_ram_param: parametrised single-port synchronous RAM.
// Has width and depth parameters, byte write enables, a selectable read
// latency and write-read behaviour, and an output-valid flag.
// Optional feature macro: SP_RAM_CLEAR_EN. When it is defined, a clear engine
// writes CLEAR_VAL to every word after reset and holds busy high meanwhile.
module sp_ram_param #(
  parameter int                 DATA_W     = 16,
  parameter int                 ADDR_W     = 10,
  parameter int                 DEPTH      = 1024,
  parameter int                 READ_MODE  = 0,
  parameter int                 WRITE_MODE = 0,
  parameter logic [DATA_W-1:0]  CLEAR_VAL  = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ce,
  input  logic                  oce,
  input  logic                  wre,
  input  logic [ADDR_W-1:0]     ad,
  input  logic [DATA_W-1:0]     din,
  input  logic [DATA_W/8-1:0]   be,
  output logic [DATA_W-1:0]     dout,
  output logic                  dout_valid,
  output logic                  busy
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic [DATA_W-1:0] rd_q;
  logic              rd_vld_q;
  logic [DATA_W-1:0] out_q;
  logic              out_vld_q;

  logic              acc;
  logic              in_range;
  logic [DATA_W-1:0] old_w;
  logic [DATA_W-1:0] merged_w;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

`ifdef SP_RAM_CLEAR_EN
  // state   | meaning
  // S_IDLE  | normal operation, user accesses accepted
  // S_CLEAR | writing CLEAR_VAL to one word per cycle, user accesses ignored
  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] clr_addr_q;
  logic              busy_q;

  // Clear sequencer: walks addresses 0..DEPTH-1 after every reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= S_CLEAR;
      clr_addr_q <= '0;
      busy_q     <= 1'b1;
    end else begin
      case (state_q)
        S_CLEAR: begin
          if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            clr_addr_q <= clr_addr_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_we   = (state_q == S_CLEAR);
  assign clr_addr = clr_addr_q;
  assign busy     = busy_q;
`else
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
  assign busy     = 1'b0;
`endif

  assign acc      = ce && !busy;
  assign in_range = (32'(ad) < 32'(DEPTH));

  // Old word at the address (0 when out of range) and the byte-merged new word
  always_comb begin
    old_w    = in_range ? mem[ad] : '0;
    merged_w = old_w;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) merged_w[8*i +: 8] = din[8*i +: 8];
    end
  end

  // Array write port. A write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (clr_we) begin
        mem[clr_addr] <= CLEAR_VAL;
      end else if (acc && wre && in_range) begin
        for (int i = 0; i < NB; i++) begin
          if (be[i]) mem[ad][8*i +: 8] <= din[8*i +: 8];
        end
      end
    end
  end

  // Read register: loads on reads, and on writes according to WRITE_MODE
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_q     <= '0;
      rd_vld_q <= 1'b0;
    end else if (acc) begin
      if (!wre) begin
        rd_q     <= old_w;
        rd_vld_q <= 1'b1;
      end else if (WRITE_MODE == 1) begin
        rd_q     <= merged_w;
        rd_vld_q <= 1'b1;
      end else if (WRITE_MODE == 2) begin
        rd_q     <= old_w;
        rd_vld_q <= 1'b1;
      end
    end
  end

  // Output register used by the two-cycle read mode; valid travels with data
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else if (oce) begin
      out_q     <= rd_q;
      out_vld_q <= rd_vld_q;
    end
  end

  assign dout       = (READ_MODE == 1) ? out_q     : rd_q;
  assign dout_valid = (READ_MODE == 1) ? out_vld_q : rd_vld_q;

endmodule
